l2_cache_nway: RTL
==================

Name: l2_cache_nway

Overview:
Parametrised successor to the fixed 4-way L2 datapath. It is a complete write-back, write-allocate, N-way set-associative L2 cache: datapath plus its own control FSM and tree-PLRU replacement. It adds a whole-cache flush (write back all dirty lines) for coherence and DMA hand-off. It sits between the L1 arbiter (line-granular requests) and physical memory.

Parameters:
S_OFFSET, 5, log2 bytes per line; line width LINE = 8*2^S_OFFSET bits
S_INDEX, 3, log2 number of sets; NUM_SETS = 2^S_INDEX
NUM_WAYS, 4, associativity; power of 2, 2..16
S_TAG, 32-S_OFFSET-S_INDEX, tag width (derived, not overridden)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-low
mem_read  in  1  line read request; held until mem_resp
mem_write  in  1  line write request; held until mem_resp
mem_address  in  32  request address; offset bits ignored
mem_byte_enable  in  2^S_OFFSET  per-byte write enable
mem_wdata  in  LINE  write data
mem_rdata  out  LINE  read data, valid when mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  memory line read; held until pmem_resp
pmem_write  out  1  memory line write; held until pmem_resp
pmem_address  out  32  line-aligned memory address
pmem_wdata  out  LINE  writeback data
pmem_rdata  in  LINE  fill data, valid with pmem_resp
pmem_resp  in  1  memory completion pulse
flush_req  in  1  start whole-cache flush; sampled in IDLE only
flush_busy  out  1  high from flush start to flush_done
flush_done  out  1  one-cycle pulse when flush completes

Behaviour:
- Reset (rst=0 at an edge, any state): FSM->IDLE; all valid, dirty and PLRU bits cleared. mem_resp, pmem_read, pmem_write, flush_busy and flush_done are 0. Any in-flight pmem transaction is abandoned. Tag and data arrays are not reset.
- Address split: index = addr[S_OFFSET+S_INDEX-1:S_OFFSET]; tag = addr[31:S_OFFSET+S_INDEX].
- Arrays: flop-based, combinational read, write on clock edge.
- States: IDLE, CHECK, WRITEBACK, FILL, FL_SCAN, FL_WB, FL_DONE.
- IDLE: mem_read|mem_write -> CHECK. Otherwise flush_req -> FL_SCAN with set counter=0 and way counter=0. A CPU request wins over a simultaneous flush_req.
- If mem_read and mem_write are both high, the request is treated as a write.
- CHECK, hit (valid and tag match, at most one way):
  - mem_resp=1 for this cycle; mem_rdata = hit line.
  - On a write, bytes with mem_byte_enable=1 take mem_wdata and the dirty bit is set.
  - PLRU is updated; next state IDLE.
  - Hit latency: 2 cycles from request to mem_resp.
- CHECK, miss: victim = lowest-index invalid way, else the PLRU victim. The victim is registered. If victim valid and dirty -> WRITEBACK, else -> FILL.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim line.
  - On pmem_resp: clear victim dirty -> FILL.
- FILL:
  - pmem_read=1; pmem_address = {tag, index, 0}.
  - On pmem_resp: victim line <= pmem_rdata, tag written, valid=1, dirty=0 -> CHECK. The retried CHECK hits and applies any write.
- pmem_resp outside WRITEBACK, FILL and FL_WB is ignored.
- PLRU encoding: NUM_WAYS-1 bits per set in heap order. Node k is stored at bit k-1; its children are nodes 2k and 2k+1.
  - Bit value 0: victim search goes to the left (lower-way) subtree. Bit value 1: right subtree.
  - On a hit or fill of way w, every node on w's root-to-leaf path is set to point away from w.
- Flush:
  - FL_SCAN visits (set, way) in order: way fastest, then set.
  - Valid and dirty entry -> FL_WB: writeback as in WRITEBACK, clear dirty on pmem_resp, return to FL_SCAN at the next entry.
  - Non-dirty entries cost one cycle each.
  - After entry (NUM_SETS-1, NUM_WAYS-1) -> FL_DONE: flush_done=1 for one cycle, flush_busy=0, -> IDLE.
  - Valid bits and PLRU are unchanged by a flush.
- flush_busy=1 in FL_SCAN, FL_WB and FL_DONE. CPU requests wait in IDLE until the flush completes.
- mem_rdata is don't-care when mem_resp=0.

Test Plan:
- Cold read: after reset, read 0x0000_0120 -> pmem_read with pmem_address=0x0000_0120; pmem_resp with line A; next CHECK gives mem_resp=1, mem_rdata=A, 4 cycles from request when pmem_resp is immediate.
- Hit/write: write 0x0000_0120 with byte_enable=0x0000_000F, wdata=all-ones, then read -> 2-cycle hit; bytes 0..3 = 0xFF, rest = A; no pmem activity.
- PLRU (NUM_WAYS=4): fill set 0 with 0x000, 0x100, 0x200, 0x300, read 0x000, then read 0x400 -> victim way 2 (tag 0x2); a following read of 0x200 misses.
- Dirty eviction: dirty way 2 as the victim -> pmem_write with address 0x0000_0200 and the old line before pmem_read 0x0000_0400.
- Flush: 3 dirty lines -> exactly 3 pmem_writes in (set, way) order, then flush_done pulse; a second flush gives 0 pmem_writes and flush_done after NUM_SETS*NUM_WAYS+1 cycles.
- Reset mid-FILL: rst=0 while pmem_read=1 -> next cycle pmem_read=0, FSM in IDLE; a read of the same address misses again.

Source files
------------

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 cache with tree-PLRU
// replacement and a whole-cache flush that writes back every dirty line.
module l2_cache_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [31:0]                mem_address,
    input  logic [(1<<S_OFFSET)-1:0]   mem_byte_enable,
    input  logic [(8<<S_OFFSET)-1:0]   mem_wdata,
    output logic [(8<<S_OFFSET)-1:0]   mem_rdata,
    output logic                       mem_resp,
    output logic                       pmem_read,
    output logic                       pmem_write,
    output logic [31:0]                pmem_address,
    output logic [(8<<S_OFFSET)-1:0]   pmem_wdata,
    input  logic [(8<<S_OFFSET)-1:0]   pmem_rdata,
    input  logic                       pmem_resp,
    input  logic                       flush_req,
    output logic                       flush_busy,
    output logic                       flush_done
);
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int LINE     = 8 << S_OFFSET;
    localparam int BYTES    = 1 << S_OFFSET;
    localparam int NUM_SETS = 1 << S_INDEX;
    localparam int S_WAY    = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_WRITEBACK, ST_FILL, ST_FL_SCAN, ST_FL_WB, ST_FL_DONE
    } state_t;

    state_t                r_state, w_next_state;
    logic [LINE-1:0]       r_data  [NUM_SETS][NUM_WAYS];
    logic [S_TAG-1:0]      r_tag   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0]   r_dirty [NUM_SETS];
    logic [NUM_WAYS-2:0]   r_plru  [NUM_SETS];
    logic [S_WAY-1:0]      r_victim;
    logic [S_INDEX-1:0]    r_fl_set;
    logic [S_WAY-1:0]      r_fl_way;

    logic [S_INDEX-1:0]    w_idx;
    logic [S_TAG-1:0]      w_tag;
    logic                  w_hit, w_inv_found;
    logic [S_WAY-1:0]      w_hit_way, w_inv_way, w_victim;
    logic [LINE-1:0]       w_hit_line, w_merged;
    logic                  w_fl_dirty, w_fl_last;
    logic                  w_hit_upd, w_fill_upd, w_wb_clr, w_fl_clr, w_fl_adv, w_fl_start, w_victim_ld;
    logic                  w_unused_offset;

    assign w_idx           = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign w_tag           = mem_address[31:S_OFFSET+S_INDEX];
    assign w_unused_offset = &{1'b0, mem_address[S_OFFSET-1:0]};
    assign w_hit_line      = r_data[w_idx][w_hit_way];
    assign w_fl_dirty      = r_valid[r_fl_set][r_fl_way] && r_dirty[r_fl_set][r_fl_way];
    assign w_fl_last       = (r_fl_set == '1) && (r_fl_way == '1);

    // Walk the heap-ordered tree: bit 0 -> left (lower ways), bit 1 -> right.
    function automatic logic [S_WAY-1:0] plru_victim(input logic [NUM_WAYS-2:0] p);
        int unsigned node;
        node = 1;
        for (int unsigned l = 0; l < S_WAY; l++)
            node = 2 * node + (p[node-1] ? 1 : 0);
        return S_WAY'(node - NUM_WAYS);
    endfunction

    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] p,
                                                       input logic [S_WAY-1:0] w);
        logic [NUM_WAYS-2:0] q;
        int unsigned         node;
        logic                dir;
        q    = p;
        node = 1;
        for (int unsigned l = 0; l < S_WAY; l++) begin
            dir       = w[S_WAY-1-l];
            q[node-1] = ~dir;
            node      = 2 * node + (dir ? 1 : 0);
        end
        return q;
    endfunction

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = S_WAY'(w);
            end
            if (!r_valid[w_idx][w] && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_inv_way   = S_WAY'(w);
            end
        end
        w_victim = w_inv_found ? w_inv_way : plru_victim(r_plru[w_idx]);
        w_merged = w_hit_line;
        for (int unsigned b = 0; b < BYTES; b++)
            if (mem_byte_enable[b]) w_merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end

    always_comb begin
        w_next_state = r_state;
        mem_rdata    = w_hit_line;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        flush_busy   = 1'b0;
        flush_done   = 1'b0;
        w_hit_upd    = 1'b0;
        w_fill_upd   = 1'b0;
        w_wb_clr     = 1'b0;
        w_fl_clr     = 1'b0;
        w_fl_adv     = 1'b0;
        w_fl_start   = 1'b0;
        w_victim_ld  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    w_next_state = ST_CHECK;
                end else if (flush_req) begin
                    w_fl_start   = 1'b1;
                    w_next_state = ST_FL_SCAN;
                end
            end
            ST_CHECK: begin
                if (w_hit) begin
                    mem_resp     = 1'b1;
                    w_hit_upd    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_victim_ld  = 1'b1;
                    w_next_state = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                                   ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_idx][r_victim], w_idx, {S_OFFSET{1'b0}}};
                pmem_wdata   = r_data[w_idx][r_victim];
                if (pmem_resp) begin
                    w_wb_clr     = 1'b1;
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    w_fill_upd   = 1'b1;
                    w_next_state = ST_CHECK;
                end
            end
            ST_FL_SCAN: begin
                flush_busy = 1'b1;
                if (w_fl_dirty) begin
                    w_next_state = ST_FL_WB;
                end else begin
                    w_fl_adv     = 1'b1;
                    w_next_state = w_fl_last ? ST_FL_DONE : ST_FL_SCAN;
                end
            end
            ST_FL_WB: begin
                flush_busy   = 1'b1;
                pmem_write   = 1'b1;
                pmem_address = {r_tag[r_fl_set][r_fl_way], r_fl_set, {S_OFFSET{1'b0}}};
                pmem_wdata   = r_data[r_fl_set][r_fl_way];
                if (pmem_resp) begin
                    w_fl_clr     = 1'b1;
                    w_fl_adv     = 1'b1;
                    w_next_state = w_fl_last ? ST_FL_DONE : ST_FL_SCAN;
                end
            end
            ST_FL_DONE: begin
                flush_busy   = 1'b1;
                flush_done   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_victim <= '0;
            r_fl_set <= '0;
            r_fl_way <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (w_victim_ld) r_victim <= w_victim;
            if (w_fl_start)    {r_fl_set, r_fl_way} <= '0;
            else if (w_fl_adv) {r_fl_set, r_fl_way} <= {r_fl_set, r_fl_way} + 1'b1;
            if (w_hit_upd) begin
                r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                if (mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (w_fill_upd) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
                r_plru[w_idx]            <= plru_touch(r_plru[w_idx], r_victim);
            end
            if (w_wb_clr) r_dirty[w_idx][r_victim]    <= 1'b0;
            if (w_fl_clr) r_dirty[r_fl_set][r_fl_way] <= 1'b0;
        end
    end

    // Tag/data storage carries no reset; validity alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_fill_upd) begin
            r_data[w_idx][r_victim] <= pmem_rdata;
            r_tag[w_idx][r_victim]  <= w_tag;
        end else if (w_hit_upd && mem_write) begin
            r_data[w_idx][w_hit_way] <= w_merged;
        end
    end
endmodule
